// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner and IF/ID register of the 5-stage pipeline front end
// ports:
//   clk, rst                    clock, synchronous active-high reset
//   stall                       hazard-unit stall; holds PC, IF/ID and counters
//   branch_taken, branch_target EX-stage redirect (highest priority)
//   jump                        decoder Jump for the instruction held in IF/ID
//   imem_addr, imem_rdata       combinational instruction memory read
//   imem_ready                  0 = memory wait state, a bubble is inserted
//   if_id_instr/pc4/valid/op    IF/ID register; op feeds the main decoder
//   fetch_count, bubble_count   captured instructions / NOP insertions since reset
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h00000000,
   parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic [5:0]  if_id_op,
   output logic [31:0] fetch_count,
   output logic [31:0] bubble_count
);
   logic [31:0] pc;
   logic [31:0] pc4;
   logic [31:0] jump_target;
   assign pc4         = pc + 32'd4;
   // the jump sits in IF/ID, so its region bits come from its own PC+4
   assign jump_target = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};
   assign imem_addr   = pc;
   assign if_id_op    = if_id_instr[31:26];
   always_ff @(posedge clk) begin
      if (rst) begin
         pc           <= RESET_PC;
         if_id_instr  <= NOP_INSTR;
         if_id_pc4    <= 32'd0;
         if_id_valid  <= 1'b0;
         fetch_count  <= 32'd0;
         bubble_count <= 32'd0;
      end else if (branch_taken || (jump && !stall) || (!stall && !imem_ready)) begin
         // every bubble case shares the IF/ID flush; only the PC update differs
         pc           <= branch_taken ? branch_target : jump ? jump_target : pc;
         if_id_instr  <= NOP_INSTR;
         if_id_pc4    <= 32'd0;
         if_id_valid  <= 1'b0;
         bubble_count <= bubble_count + 32'd1;
      end else if (!stall) begin
         pc           <= pc4;
         if_id_instr  <= imem_rdata;
         if_id_pc4    <= pc4;
         if_id_valid  <= 1'b1;
         fetch_count  <= fetch_count + 32'd1;
      end
   end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
   logic        clk = 1'b0;
   logic        rst, stall, branch_taken, jump, imem_ready;
   logic [31:0] branch_target, imem_addr, imem_rdata;
   logic [31:0] if_id_instr, if_id_pc4, fetch_count, bubble_count;
   logic        if_id_valid;
   logic [5:0]  if_id_op;
   int checks = 0;
   int failures = 0;

   instruction_fetch_unit dut (
      .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .jump(jump), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_ready(imem_ready), .if_id_instr(if_id_instr),
      .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .if_id_op(if_id_op),
      .fetch_count(fetch_count), .bubble_count(bubble_count)
   );

   always #5 clk = ~clk;

   // memory: a j 0x40 at 0x00400004, otherwise a recognisable tag of the address
   assign imem_rdata = (imem_addr == 32'h00400004) ? 32'h08000010 : {16'hC0DE, imem_addr[15:0]};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 0; stall = 0; branch_taken = 0; jump = 0; imem_ready = 1; branch_target = 0;
   endtask

   task automatic expect_state(input string name, input logic [31:0] addr, input logic [31:0] instr,
                               input logic [31:0] pc4, input logic valid,
                               input logic [31:0] fc, input logic [31:0] bc);
      checks++;
      if (imem_addr !== addr) begin failures++; $display("FAIL %s imem_addr got=%h exp=%h", name, imem_addr, addr); end
      checks++;
      if (if_id_instr !== instr) begin failures++; $display("FAIL %s if_id_instr got=%h exp=%h", name, if_id_instr, instr); end
      checks++;
      if (if_id_pc4 !== pc4) begin failures++; $display("FAIL %s if_id_pc4 got=%h exp=%h", name, if_id_pc4, pc4); end
      checks++;
      if (if_id_valid !== valid) begin failures++; $display("FAIL %s if_id_valid got=%b exp=%b", name, if_id_valid, valid); end
      checks++;
      if (fetch_count !== fc) begin failures++; $display("FAIL %s fetch_count got=%0d exp=%0d", name, fetch_count, fc); end
      checks++;
      if (bubble_count !== bc) begin failures++; $display("FAIL %s bubble_count got=%0d exp=%0d", name, bubble_count, bc); end
   endtask

   task automatic test_reset();
      idle();
      rst = 1;
      step();
      expect_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 0, 0);
      checks++;
      if (if_id_op !== 6'b000000) begin failures++; $display("FAIL reset_op got=%b exp=000000", if_id_op); end
      rst = 0;
   endtask

   task automatic test_sequential();
      idle();
      step(); expect_state("seq0", 32'h4,  32'hC0DE0000, 32'h4,  1'b1, 1, 0);
      checks++;
      if (if_id_op !== 6'b110000) begin failures++; $display("FAIL seq_op got=%b exp=110000", if_id_op); end
      step(); expect_state("seq1", 32'h8,  32'hC0DE0004, 32'h8,  1'b1, 2, 0);
      step(); expect_state("seq2", 32'hC,  32'hC0DE0008, 32'hC,  1'b1, 3, 0);
      step(); expect_state("seq3", 32'h10, 32'hC0DE000C, 32'h10, 1'b1, 4, 0);
   endtask

   task automatic test_jump();
      idle();
      branch_taken = 1; branch_target = 32'h00400004;
      step(); expect_state("jmp_setup_br", 32'h00400004, 32'h0, 32'h0, 1'b0, 4, 1);
      idle();
      step(); expect_state("jmp_setup_fetch", 32'h00400008, 32'h08000010, 32'h00400008, 1'b1, 5, 1);
      checks++;
      if (if_id_op !== 6'b000010) begin failures++; $display("FAIL jmp_op got=%b exp=000010", if_id_op); end
      jump = 1;
      step(); expect_state("jmp_taken", 32'h00000040, 32'h0, 32'h0, 1'b0, 5, 2);
      jump = 0;
      step(); expect_state("jmp_target_fetch", 32'h44, 32'hC0DE0040, 32'h44, 1'b1, 6, 2);
   endtask

   task automatic test_branch_priority();
      idle();
      branch_taken = 1; branch_target = 32'h00000100; stall = 1; jump = 1; imem_ready = 0;
      step(); expect_state("br_prio", 32'h100, 32'h0, 32'h0, 1'b0, 6, 3);
      idle();
      step(); expect_state("br_target_fetch", 32'h104, 32'hC0DE0100, 32'h104, 1'b1, 7, 3);
   endtask

   task automatic test_stall();
      idle();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         imem_ready = i[0];
         jump = (i == 1);
         step(); expect_state($sformatf("stall%0d", i), 32'h104, 32'hC0DE0100, 32'h104, 1'b1, 7, 3);
      end
      idle();
      step(); expect_state("stall_release", 32'h108, 32'hC0DE0104, 32'h108, 1'b1, 8, 3);
   endtask

   task automatic test_wait();
      idle();
      rst = 1;
      step();
      idle();
      branch_taken = 1; branch_target = 32'h20;
      step(); expect_state("wait_br", 32'h20, 32'h0, 32'h0, 1'b0, 0, 1);
      idle();
      imem_ready = 0;
      step();
      checks++;
      if (imem_addr !== 32'h20 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || bubble_count !== 32'd2)
         begin failures++; $display("FAIL wait0 addr=%h valid=%b instr=%h bc=%0d exp 20/0/0/2", imem_addr, if_id_valid, if_id_instr, bubble_count); end
      step();
      checks++;
      if (imem_addr !== 32'h20 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || bubble_count !== 32'd3)
         begin failures++; $display("FAIL wait1 addr=%h valid=%b instr=%h bc=%0d exp 20/0/0/3", imem_addr, if_id_valid, if_id_instr, bubble_count); end
      imem_ready = 1;
      step(); expect_state("wait_capture", 32'h24, 32'hC0DE0020, 32'h24, 1'b1, 1, 3);
   endtask

   task automatic test_back_to_back();
      idle();
      branch_taken = 1; branch_target = 32'hFFFFFFFC;
      step(); expect_state("wrap_br", 32'hFFFFFFFC, 32'h0, 32'h0, 1'b0, 1, 4);
      idle();
      step(); expect_state("wrap_fetch", 32'h0, 32'hC0DEFFFC, 32'h0, 1'b1, 2, 4);
      step(); expect_state("wrap_next", 32'h4, 32'hC0DE0000, 32'h4, 1'b1, 3, 4);
      rst = 1; branch_taken = 1; branch_target = 32'h300; jump = 1; imem_ready = 0;
      step(); expect_state("mid_reset", 32'h0, 32'h0, 32'h0, 1'b0, 0, 0);
      idle();
      step(); expect_state("post_reset", 32'h4, 32'hC0DE0000, 32'h4, 1'b1, 1, 0);
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_jump();
      test_branch_priority();
      test_stall();
      test_wait();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
